// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU.
//   OP_W     - opcode width in bits
//   alu_op_e - opcode encoding, which the sel input carries
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the ALU.
//   A, B      - WIDTH-bit unsigned operands (master -> slave)
//   sel       - opcode (master -> slave)
//   in_valid  - operands/opcode valid this cycle (master -> slave)
//   out       - WIDTH+1-bit registered result (slave -> master)
//   out_valid - out/zero hold the result of an in_valid cycle (slave -> master)
//   zero      - registered flag, out[WIDTH-1:0] == 0 (slave -> master)
interface alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OP_W-1:0]  sel;
  logic             in_valid;
  logic [WIDTH:0]   out;
  logic             out_valid;
  logic             zero;

  modport master (
    output A, B, sel, in_valid,
    input  out, out_valid, zero
  );

  modport slave (
    input  A, B, sel, in_valid,
    output out, out_valid, zero
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   i_a, i_b  - WIDTH-bit unsigned operands
//   i_sel     - opcode (alu_op_e encoding)
//   o_result  - WIDTH+1-bit result; MSB is carry, borrow or shifted-out bit
//   o_zero    - 1 when o_result[WIDTH-1:0] == 0 (MSB excluded)
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_sel,
  output logic [WIDTH:0]   o_result,
  output logic             o_zero
);

  logic [WIDTH:0] w_result;

  always_comb begin
    w_result = '0;
    case (alu_op_e'(i_sel))
      OP_ADD:  w_result = {1'b0, i_a} + {1'b0, i_b};
      // Extended subtraction: MSB ends up set exactly when i_a < i_b.
      OP_SUB:  w_result = {1'b0, i_a} - {1'b0, i_b};
      OP_OR:   w_result = {1'b0, i_a | i_b};
      OP_AND:  w_result = {1'b0, i_a & i_b};
      OP_XOR:  w_result = {1'b0, i_a ^ i_b};
      OP_NOT:  w_result = {1'b0, ~i_a};
      OP_SHL:  w_result = {i_a, 1'b0};
      // Logical right shift; the bit shifted out lands in the MSB.
      OP_SHR:  w_result = {i_a[0], 1'b0, i_a[WIDTH-1:1]};
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = ~|w_result[WIDTH-1:0];

endmodule

// File: rtl/alu.sv
// alu: registered ALU with one-cycle latency and no backpressure.
//   clk - rising-edge clock
//   rst - synchronous, active-high reset; clears out, out_valid and zero
//   bus - alu_if slave: A/B/sel/in_valid in, out/out_valid/zero out
// out and zero hold their last values while in_valid is low.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic [WIDTH:0] w_result;
  logic           w_zero;

  logic [WIDTH:0] r_out;
  logic           r_out_valid;
  logic           r_zero;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_sel    (bus.sel),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out  <= w_result;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed, self-checking bench for alu (WIDTH=4).
// Expected results are pushed to a scoreboard queue when an operation is
// issued and popped when out_valid reports it.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W:0] out;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t sb[$];
  exp_t last_exp;

  int n_checks = 0;
  int n_errors = 0;

  alu_if #(.WIDTH(W)) bus ();

  alu #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, let the edge happen, then check #1 after it.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic v, input logic r,
                      input logic [W:0] exp_out, input logic exp_zero);
    exp_t e;
    logic exp_valid;
    bus.A        = a;
    bus.B        = b;
    bus.sel      = op;
    bus.in_valid = v;
    rst          = r;
    exp_valid    = v && !r;
    if (exp_valid) begin
      e.out  = exp_out;
      e.zero = exp_zero;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, exp_valid});
    if (r) begin
      last_exp = '0;
    end else if (exp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
      end else begin
        last_exp = sb.pop_front();
      end
    end
    check({tag, ".out"}, bus.out, last_exp.out);
    check({tag, ".zero"}, {{W{1'b0}}, bus.zero}, {{W{1'b0}}, last_exp.zero});
  endtask

  initial begin
    bus.A        = '0;
    bus.B        = '0;
    bus.sel      = '0;
    bus.in_valid = 1'b0;
    last_exp     = '0;

    step("reset0", 4'b0000, 4'b0000, OP_ADD, 1'b0, 1'b1, 5'b00000, 1'b0);
    step("reset1", 4'b1111, 4'b1111, OP_ADD, 1'b0, 1'b1, 5'b00000, 1'b0);

    step("add",      4'b1001, 4'b0011, OP_ADD, 1'b1, 1'b0, 5'b01100, 1'b0);
    step("and",      4'b0111, 4'b1010, OP_AND, 1'b1, 1'b0, 5'b00010, 1'b0);
    step("add_ovf",  4'b1111, 4'b0001, OP_ADD, 1'b1, 1'b0, 5'b10000, 1'b1);
    step("sub_brw",  4'b0011, 4'b0101, OP_SUB, 1'b1, 1'b0, 5'b11110, 1'b0);
    step("sub_eq",   4'b0101, 4'b0101, OP_SUB, 1'b1, 1'b0, 5'b00000, 1'b1);
    step("sub_pos",  4'b1000, 4'b0011, OP_SUB, 1'b1, 1'b0, 5'b00101, 1'b0);
    step("shl",      4'b1011, 4'b0110, OP_SHL, 1'b1, 1'b0, 5'b10110, 1'b0);
    step("shr",      4'b1011, 4'b0110, OP_SHR, 1'b1, 1'b0, 5'b10101, 1'b0);
    step("shr_z",    4'b0001, 4'b1111, OP_SHR, 1'b1, 1'b0, 5'b10000, 1'b1);
    step("or",       4'b1100, 4'b1010, OP_OR,  1'b1, 1'b0, 5'b01110, 1'b0);
    step("xor",      4'b1100, 4'b1010, OP_XOR, 1'b1, 1'b0, 5'b00110, 1'b0);
    step("not",      4'b1100, 4'b1010, OP_NOT, 1'b1, 1'b0, 5'b00011, 1'b0);

    // Idle cycles with changing operands: outputs must hold.
    step("hold0",    4'b1111, 4'b1111, OP_ADD, 1'b0, 1'b0, 5'b00000, 1'b0);
    step("hold1",    4'b0000, 4'b0000, OP_SUB, 1'b0, 1'b0, 5'b00000, 1'b0);

    step("add_ovf2", 4'b1111, 4'b0001, OP_ADD, 1'b1, 1'b0, 5'b10000, 1'b1);
    // Reset wins over in_valid and clears a set zero flag.
    step("rst_iv",   4'b1001, 4'b0011, OP_ADD, 1'b1, 1'b1, 5'b00000, 1'b0);
    step("post_rst", 4'b1001, 4'b0011, OP_ADD, 1'b0, 1'b0, 5'b00000, 1'b0);
    step("resume",   4'b1001, 4'b0011, OP_ADD, 1'b1, 1'b0, 5'b01100, 1'b0);
    step("not_b",    4'b0000, 4'b0101, OP_NOT, 1'b1, 1'b0, 5'b01111, 1'b0);

    check("sb_empty", W'(sb.size()) + 5'b0, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
